digit_scan_scheduler: RTL and testbench
=======================================

# digit_scan_scheduler

Time-multiplexing scheduler for the shared seven-segment decoder and the per-digit common-enable transistors of the dual-display board. It cycles a digit index through `NUM_DIGITS` positions and inserts a blanking gap before each digit turns on, so the shared segment bus settles with every digit off (no ghosting). It also applies 8-level PWM brightness within each digit's dwell. It sits between the top level and the segment decoder / display enable pins: `digit_sel` steers the decoder's input mux and `digit_en` drives the display enables.

## Interface
- `NUM_DIGITS`, 2: number of multiplexed digits; ≥ 2.
- `DWELL_CYCLES`, 24000: clock cycles per digit ON slot; multiple of 8, ≥ 8 (1 kHz per digit at 24 MHz).
- `BLANK_CYCLES`, 240: clock cycles of all-off gap before each ON slot; ≥ 1.
- `clk`  in  1  system clock (HSOSC-derived).
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  scan run; low forces idle.
- `brightness`  in  3  duty level 0..7; on-time = (brightness+1)/8 of dwell.
- `digit_sel`  out  max(1, clog2(NUM_DIGITS))  index of the digit whose data the decoder must present.
- `digit_en`  out  NUM_DIGITS  one-hot-or-zero, active-high digit enables.
- `blank`  out  1  high whenever `digit_en` == 0.
- `frame_start`  out  1  one-cycle pulse on the first ON cycle of digit 0.

## Operation
- One clock and one reset; reset is synchronous and active-high.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- Reset values: state IDLE, `digit_sel`=0, `digit_en`=0, `blank`=1, `frame_start`=0, counters 0.
- FSM states: IDLE, BLANK, ON.
  - IDLE: all digits off. When `enable`=1, go to BLANK with the counter cleared.
  - BLANK: all digits off for exactly BLANK_CYCLES cycles, then go to ON.
  - ON: runs for exactly DWELL_CYCLES cycles. On the last cycle, `digit_sel` advances (NUM_DIGITS-1 wraps to 0) and the state goes to BLANK.
- `digit_sel` changes only on the ON→BLANK transition. It is therefore stable through every BLANK and ON slot.
- Brightness handling:
  - `brightness` is sampled on the BLANK→ON transition: on_cycles = ((brightness+1)·DWELL_CYCLES)>>3.
  - `digit_en[digit_sel]`=1 during the first on_cycles cycles of ON and 0 for the remainder.
  - A change to `brightness` during ON takes effect in the next ON slot.
- `enable`=0 in any state: the next state is IDLE, `digit_en`=0, and `digit_sel` is reset to 0. Re-enabling always restarts with BLANK for digit 0.
- Reset dominates `enable`.
- Counter width: clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). Compute on_cycles with at least 3 extra bits so the multiply cannot overflow.

## Timing
- `enable` sampled high at edge t0 (state IDLE):
  - BLANK occupies cycles t0+1 … t0+BLANK_CYCLES.
  - The first ON cycle is t0+BLANK_CYCLES+1. `digit_en[0]` and `frame_start` are high in that cycle.
- Slot period = BLANK_CYCLES + DWELL_CYCLES. Frame period = NUM_DIGITS · slot period. `frame_start` repeats at the frame period.
- `enable` dropped (sampled low at edge t): outputs are off from cycle t+1.
- Reset asserted at edge t: outputs are at reset values from cycle t+1.

## Structure
- Package `display_pkg`:
  - `scan_state_t` enum {IDLE, BLANK, ON}.
  - `BRIGHT_W`=3.
  - Default timing constants (DWELL_CYCLES, BLANK_CYCLES at 24 MHz).
- One sub-module, `scan_timer`: a loadable down-counter with `load`, `load_val`, and a `done` output. It is reused for both the BLANK and ON durations. The FSM and the PWM comparison stay in `digit_scan_scheduler`.
- Top-level integration: replaces the existing two-digit enable FSM. `digit_sel` feeds the decoder mux.

## Test plan
All scenarios use NUM_DIGITS=2, DWELL_CYCLES=16, BLANK_CYCLES=2 unless noted.
- Reset held 5 cycles with `enable`=1 → `digit_en`=00, `blank`=1, `digit_sel`=0, `frame_start`=0 throughout.
- `enable`=1, `brightness`=7 → `digit_en` follows the repeating pattern 00×2, 01×16, 00×2, 10×16. `frame_start` is high 1 cycle every 36 cycles. `digit_sel` toggles only at ON→BLANK.
- `brightness`=3 → on_cycles=8: each ON slot is 8 cycles enabled then 8 cycles off. `brightness`=0 → 2 cycles enabled then 14 off.
- `brightness` changed 7→1 at cycle 5 of digit 0's ON → that slot stays fully lit (16 cycles). Digit 1's slot is lit for 4 cycles.
- `enable` dropped mid-ON on digit 1 → `digit_en`=00 and `digit_sel`=0 the next cycle. Re-enabling gives 2 BLANK cycles, then digit 0 with `frame_start`.
- NUM_DIGITS=3 → digit order 0,1,2,0 with 3-bit `digit_en` 001, 010, 100 and `digit_sel` wrapping 2→0. Synchronous reset asserted mid-ON → reset values at the next edge.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared scan states, brightness width and default 24 MHz timing
package display_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ON} scan_state_t;
  localparam int BRIGHT_W = 3;
  localparam int DEF_DWELL_CYCLES = 24000;
  localparam int DEF_BLANK_CYCLES = 240;
endpackage

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter, done while the count sits at zero
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         done
);
  assign done = count == '0;
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (!done) count <= count - W'(1);
endmodule

// File: rtl/digit_scan_scheduler.sv
// digit_scan_scheduler: blanked, PWM-dimmed digit multiplexing for a shared segment bus
module digit_scan_scheduler
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int SW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = $clog2((DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [SW-1:0]         digit_sel,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  blank,
  output logic                  frame_start
);
  localparam int PW = CW + 3;
  scan_state_t state, state_d;
  logic [SW-1:0] sel_d;
  logic [CW-1:0] on_cycles, on_d, load_val, count;
  logic load, done, lit;
  scan_timer #(.W(CW)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .count(count), .done(done)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      digit_sel <= '0;
      on_cycles <= '0;
    end else begin
      state <= state_d;
      digit_sel <= sel_d;
      on_cycles <= on_d;
    end
  always_comb begin
    state_d = state;
    sel_d = digit_sel;
    on_d = on_cycles;
    load = 1'b0;
    load_val = CW'(BLANK_CYCLES - 1);
    if (!enable) begin
      state_d = IDLE;
      sel_d = '0;
    end else
      case (state)
        IDLE: begin
          state_d = BLANK;
          load = 1'b1;
        end
        BLANK: if (done) begin
          state_d = ON;
          load = 1'b1;
          load_val = CW'(DWELL_CYCLES - 1);
          on_d = CW'((PW'(brightness) + PW'(1)) * PW'(DWELL_CYCLES) >> 3);
        end
        ON: if (done) begin
          state_d = BLANK;
          load = 1'b1;
          sel_d = digit_sel == SW'(NUM_DIGITS - 1) ? '0 : digit_sel + SW'(1);
        end
        default: state_d = IDLE;
      endcase
  end
  // count runs DWELL-1..0 in ON, so elapsed < on_cycles <=> count >= DWELL - on_cycles
  assign lit = state == ON && count >= CW'(DWELL_CYCLES) - on_cycles;
  assign digit_en = lit ? NUM_DIGITS'(1) << digit_sel : '0;
  assign blank = ~|digit_en;
  assign frame_start = state == ON && digit_sel == '0 && count == CW'(DWELL_CYCLES - 1);
endmodule

// File: tb/tb_digit_scan_scheduler.sv
// tb_digit_scan_scheduler: slot-arithmetic model checked every cycle on 2- and 3-digit instances
module tb_digit_scan_scheduler;
  localparam int D = 16;
  localparam int B = 2;
  localparam int SLOT = B + D;
  logic clk = 1'b0;
  logic reset, enable;
  logic [2:0] brightness;
  logic [0:0] sel0;
  logic [1:0] en0, sel1;
  logic [2:0] en1;
  logic blank0, blank1, fs0, fs1;
  int chks = 0;
  int errs = 0;
  bit m_run [2];
  int m_p [2];
  int m_lit [2];
  int n_dig [2] = '{2, 3};

  always #5 clk = ~clk;

  digit_scan_scheduler #(.NUM_DIGITS(2), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
    .digit_sel(sel0), .digit_en(en0), .blank(blank0), .frame_start(fs0)
  );
  digit_scan_scheduler #(.NUM_DIGITS(3), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
    .digit_sel(sel1), .digit_en(en1), .blank(blank1), .frame_start(fs1)
  );

  task automatic chk(input string name, input int act, input int exp);
    chks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset || !enable) m_run[i] = 1'b0;
      else if (!m_run[i]) begin
        m_run[i] = 1'b1;
        m_p[i] = 0;
      end else m_p[i]++;
      if (m_run[i] && m_p[i] % SLOT == B) m_lit[i] = ((int'(brightness) + 1) * D) >> 3;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      int off, dig, e_en, e_sel, e_fs;
      off = m_p[i] % SLOT;
      dig = (m_p[i] / SLOT) % n_dig[i];
      e_en = m_run[i] && off >= B && off - B < m_lit[i] ? 1 << dig : 0;
      e_sel = m_run[i] ? dig : 0;
      e_fs = m_run[i] && off == B && dig == 0 ? 1 : 0;
      chk($sformatf("en%0d", i), i == 0 ? int'(en0) : int'(en1), e_en);
      chk($sformatf("sel%0d", i), i == 0 ? int'(sel0) : int'(sel1), e_sel);
      chk($sformatf("blank%0d", i), i == 0 ? int'(blank0) : int'(blank1), e_en == 0 ? 1 : 0);
      chk($sformatf("fs%0d", i), i == 0 ? int'(fs0) : int'(fs1), e_fs);
    end
  end

  task automatic wait_fs(output int k);
    k = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (fs0) begin
        k = n;
        return;
      end
    end
  endtask

  initial begin
    int k, c01, c10;
    reset = 1'b1;
    enable = 1'b1;
    brightness = 3'd7;
    repeat (5) begin
      @(negedge clk);
      chk("rst_en0", en0, 0);
      chk("rst_blank0", blank0, 1);
      chk("rst_fs0", fs0, 0);
    end
    reset = 1'b0;
    wait_fs(k);
    chk("first_fs_delay", k, 3);
    wait_fs(k);
    chk("frame_period", k, 36);
    brightness = 3'd3;
    c10 = 0;
    repeat (36) begin
      @(negedge clk);
      if (en0 == 2'b10) c10++;
    end
    chk("lit_b3", c10, 8);
    wait_fs(k);
    brightness = 3'd0;
    c10 = 0;
    repeat (36) begin
      @(negedge clk);
      if (en0 == 2'b10) c10++;
    end
    chk("lit_b0", c10, 2);
    brightness = 3'd7;
    wait_fs(k);
    chk("fs_lit", en0, 1);
    c01 = 1;
    c10 = 0;
    repeat (4) begin
      @(negedge clk);
      if (en0 == 2'b01) c01++;
    end
    brightness = 3'd1;
    repeat (31) begin
      @(negedge clk);
      if (en0 == 2'b01) c01++;
      if (en0 == 2'b10) c10++;
    end
    chk("midslot_change_d0", c01, 16);
    chk("midslot_change_d1", c10, 4);
    wait_fs(k);
    chk("resync", k, 1);
    repeat (20) @(negedge clk);
    chk("pre_drop_en0", en0, 2);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_en0", en0, 0);
    chk("drop_sel0", sel0, 0);
    chk("drop_blank0", blank0, 1);
    enable = 1'b1;
    wait_fs(k);
    chk("reenable_delay", k, 3);
    chk("d3_fs_0", fs1, 1);
    chk("d3_en_0", en1, 1);
    repeat (18) @(negedge clk);
    chk("d3_en_1", en1, 2);
    chk("d3_sel_1", sel1, 1);
    chk("d2_en_1", en0, 2);
    repeat (18) @(negedge clk);
    chk("d3_en_2", en1, 4);
    chk("d3_sel_2", sel1, 2);
    repeat (18) @(negedge clk);
    chk("d3_en_wrap", en1, 1);
    chk("d3_sel_wrap", sel1, 0);
    chk("d3_fs_wrap", fs1, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midon_rst_en1", en1, 0);
    chk("midon_rst_sel1", sel1, 0);
    chk("midon_rst_blank1", blank1, 1);
    chk("midon_rst_fs1", fs1, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    brightness = 3'd5;
    repeat (120) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", chks, errs);
    $finish;
  end
endmodule
